// File: rtl/rv32_dma_copy.sv
// Word-copy DMA initiator on the picorv32 native memory bus: one read then one write per word.
// Latency: 4 cycles/word with zero-wait responder; backpressure via mem_ready with optional timeout abort.
module rv32_dma_copy #(
    parameter int LEN_WIDTH      = 16,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic [31:0]          src_addr,
    input  logic [31:0]          dst_addr,
    input  logic [LEN_WIDTH-1:0] len_words,
    output logic                 busy,
    output logic                 done,
    output logic                 error,
    output logic                 mem_valid,
    input  logic                 mem_ready,
    output logic [31:0]          mem_addr,
    output logic [31:0]          mem_wdata,
    output logic [3:0]           mem_wstrb,
    input  logic [31:0]          mem_rdata
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_SETUP,
        S_RD_WAIT,
        S_WR_SETUP,
        S_WR_WAIT
    } state_t;

    localparam int WW        = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int TO_LAST_I = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
    localparam logic [WW-1:0] TO_LAST = TO_LAST_I[WW-1:0];
    localparam bit   TO_EN   = (TIMEOUT_CYCLES > 0);

    state_t               r_state;
    logic [31:0]          r_src;
    logic [31:0]          r_dst;
    logic [LEN_WIDTH-1:0] r_cnt;
    logic [31:0]          r_data;
    logic [WW-1:0]        r_wait;
    logic                 r_busy;
    logic                 r_done;
    logic                 r_error;
    logic                 r_mem_valid;
    logic [31:0]          r_mem_addr;
    logic [31:0]          r_mem_wdata;
    logic [3:0]           r_mem_wstrb;

    // Expires on the cycle the wait counter reaches its last value; ready in that cycle still wins.
    logic w_timeout;
    assign w_timeout = TO_EN && (r_wait == TO_LAST);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= S_IDLE;
            r_src       <= 32'h0;
            r_dst       <= 32'h0;
            r_cnt       <= '0;
            r_data      <= 32'h0;
            r_wait      <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_error     <= 1'b0;
            r_mem_valid <= 1'b0;
            r_mem_addr  <= 32'h0;
            r_mem_wdata <= 32'h0;
            r_mem_wstrb <= 4'h0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_error <= 1'b0;
                        if (len_words != '0) begin
                            r_src   <= {src_addr[31:2], 2'b00};
                            r_dst   <= {dst_addr[31:2], 2'b00};
                            r_cnt   <= len_words;
                            r_busy  <= 1'b1;
                            r_state <= S_RD_SETUP;
                        end else begin
                            r_done  <= 1'b1;
                        end
                    end
                end
                S_RD_SETUP: begin
                    r_mem_addr  <= r_src;
                    r_mem_wstrb <= 4'h0;
                    r_mem_valid <= 1'b1;
                    r_wait      <= '0;
                    r_state     <= S_RD_WAIT;
                end
                S_RD_WAIT: begin
                    if (mem_ready) begin
                        r_data      <= mem_rdata;
                        r_mem_valid <= 1'b0;
                        r_state     <= S_WR_SETUP;
                    end else if (w_timeout) begin
                        r_mem_valid <= 1'b0;
                        r_error     <= 1'b1;
                        r_done      <= 1'b1;
                        r_busy      <= 1'b0;
                        r_state     <= S_IDLE;
                    end else begin
                        r_wait <= r_wait + 1'b1;
                    end
                end
                S_WR_SETUP: begin
                    r_mem_addr  <= r_dst;
                    r_mem_wdata <= r_data;
                    r_mem_wstrb <= 4'hF;
                    r_mem_valid <= 1'b1;
                    r_wait      <= '0;
                    r_state     <= S_WR_WAIT;
                end
                S_WR_WAIT: begin
                    if (mem_ready) begin
                        r_mem_valid <= 1'b0;
                        r_src       <= r_src + 32'd4;
                        r_dst       <= r_dst + 32'd4;
                        r_cnt       <= r_cnt - 1'b1;
                        if (r_cnt == {{(LEN_WIDTH-1){1'b0}}, 1'b1}) begin
                            r_done  <= 1'b1;
                            r_busy  <= 1'b0;
                            r_state <= S_IDLE;
                        end else begin
                            r_state <= S_RD_SETUP;
                        end
                    end else if (w_timeout) begin
                        r_mem_valid <= 1'b0;
                        r_error     <= 1'b1;
                        r_done      <= 1'b1;
                        r_busy      <= 1'b0;
                        r_state     <= S_IDLE;
                    end else begin
                        r_wait <= r_wait + 1'b1;
                    end
                end
                default: begin
                    r_mem_valid <= 1'b0;
                    r_busy      <= 1'b0;
                    r_state     <= S_IDLE;
                end
            endcase
        end
    end

    assign busy      = r_busy;
    assign done      = r_done;
    assign error     = r_error;
    assign mem_valid = r_mem_valid;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign mem_wstrb = r_mem_wstrb;

endmodule

// File: tb/tb_rv32_dma_copy.sv
// Table-driven bench for rv32_dma_copy with a stalling memory responder and hand-coded corner sequences.
module tb_rv32_dma_copy;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic [31:0] src_addr;
    logic [31:0] dst_addr;
    logic [15:0] len_words;
    logic        busy;
    logic        done;
    logic        error;
    logic        mem_valid;
    logic        mem_ready;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_rdata;

    rv32_dma_copy #(.LEN_WIDTH(16), .TIMEOUT_CYCLES(8)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .src_addr  (src_addr),
        .dst_addr  (dst_addr),
        .len_words (len_words),
        .busy      (busy),
        .done      (done),
        .error     (error),
        .mem_valid (mem_valid),
        .mem_ready (mem_ready),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wstrb (mem_wstrb),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] src;
        logic [31:0] dst;
        int          len;
        int          max_stall;
        bit          never;
        int          poke;
        logic [31:0] exp_src0;
        logic [31:0] exp_dst0;
        int          exp_cyc;
        int          exp_valid;
        int          exp_n;
        logic        exp_err;
    } vec_t;

    int n_chk  = 0;
    int n_pass = 0;

    logic [31:0] rd_q[$];
    logic [31:0] wr_a_q[$];
    logic [31:0] wr_d_q[$];
    int          valid_cnt;
    int          max_stall;
    bit          never;

    function automatic logic [31:0] pat(input logic [31:0] a);
        return a ^ 32'h5A5A_1234;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    // Responder: random stall per transfer, checks request stability while stalled.
    bit          in_txn;
    int          stall_left;
    logic [31:0] h_a, h_d;
    logic [3:0]  h_s;
    initial begin
        mem_ready = 1'b0;
        mem_rdata = 32'h0;
        in_txn    = 1'b0;
        forever begin
            @(negedge clk);
            if (!reset_n || !mem_valid) begin
                mem_ready = 1'b0;
                in_txn    = 1'b0;
            end else begin
                valid_cnt++;
                if (!in_txn) begin
                    in_txn     = 1'b1;
                    h_a        = mem_addr;
                    h_d        = mem_wdata;
                    h_s        = mem_wstrb;
                    stall_left = $urandom_range(max_stall, 0);
                end else begin
                    chk("hold_addr", mem_addr, h_a);
                    chk("hold_wdata", mem_wdata, h_d);
                    chk("hold_wstrb", {28'h0, mem_wstrb}, {28'h0, h_s});
                end
                if (never) begin
                    mem_ready = 1'b0;
                end else if (stall_left == 0) begin
                    mem_ready = 1'b1;
                    if (mem_wstrb == 4'h0) begin
                        rd_q.push_back(mem_addr);
                        mem_rdata = pat(mem_addr);
                    end else begin
                        wr_a_q.push_back(mem_addr);
                        wr_d_q.push_back(mem_wdata);
                    end
                end else begin
                    stall_left--;
                    mem_ready = 1'b0;
                end
            end
        end
    end

    task automatic run_job(input vec_t v, input int idx);
        int cyc;
        rd_q.delete();
        wr_a_q.delete();
        wr_d_q.delete();
        valid_cnt = 0;
        max_stall = v.max_stall;
        never     = v.never;
        @(negedge clk);
        src_addr  = v.src;
        dst_addr  = v.dst;
        len_words = v.len[15:0];
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc   = 0;
        while (!done && cyc < 300) begin
            @(negedge clk);
            cyc++;
            start = (v.poke != 0 && cyc == v.poke);
            if (start) begin
                src_addr  = 32'h0000_9990;
                dst_addr  = 32'h0000_AAA0;
                len_words = 16'd7;
            end
        end
        start = 1'b0;
        chk($sformatf("v%0d_done_seen", idx), {31'h0, done}, 32'h1);
        if (v.exp_cyc >= 0) chk($sformatf("v%0d_cycles", idx), cyc, v.exp_cyc);
        chk($sformatf("v%0d_busy_at_done", idx), {31'h0, busy}, 32'h0);
        chk($sformatf("v%0d_error", idx), {31'h0, error}, {31'h0, v.exp_err});
        @(negedge clk);
        chk($sformatf("v%0d_done_pulse", idx), {31'h0, done}, 32'h0);
        @(negedge clk);
        chk($sformatf("v%0d_error_hold", idx), {31'h0, error}, {31'h0, v.exp_err});
        chk($sformatf("v%0d_idle_valid", idx), {31'h0, mem_valid}, 32'h0);
        if (v.exp_valid >= 0) chk($sformatf("v%0d_valid_cycles", idx), valid_cnt, v.exp_valid);
        chk($sformatf("v%0d_n_reads", idx), rd_q.size(), v.exp_n);
        chk($sformatf("v%0d_n_writes", idx), wr_a_q.size(), v.exp_n);
        for (int i = 0; i < rd_q.size(); i++)
            chk($sformatf("v%0d_rd_addr%0d", idx, i), rd_q[i], v.exp_src0 + 32'(4 * i));
        for (int i = 0; i < wr_a_q.size(); i++) begin
            chk($sformatf("v%0d_wr_addr%0d", idx, i), wr_a_q[i], v.exp_dst0 + 32'(4 * i));
            chk($sformatf("v%0d_wr_data%0d", idx, i), wr_d_q[i], pat(v.exp_src0 + 32'(4 * i)));
        end
    endtask

    vec_t vecs[8];

    initial begin
        //          src           dst           len stall nev poke exp_src0      exp_dst0     cyc valid n  err
        vecs[0] = '{32'h0000_0100, 32'h0000_0200, 3, 0, 1'b0, 0, 32'h0000_0100, 32'h0000_0200, 12,  6, 3, 1'b0};
        vecs[1] = '{32'h0000_1000, 32'h0000_3000, 5, 5, 1'b0, 0, 32'h0000_1000, 32'h0000_3000, -1, -1, 5, 1'b0};
        vecs[2] = '{32'h0000_0040, 32'h0000_0080, 0, 0, 1'b0, 0, 32'h0000_0040, 32'h0000_0080,  0,  0, 0, 1'b0};
        vecs[3] = '{32'hFFFF_FFFC, 32'h0000_0500, 2, 0, 1'b0, 3, 32'hFFFF_FFFC, 32'h0000_0500,  8,  4, 2, 1'b0};
        vecs[4] = '{32'h0000_0123, 32'h0000_0207, 1, 0, 1'b0, 0, 32'h0000_0120, 32'h0000_0204,  4,  2, 1, 1'b0};
        vecs[5] = '{32'h0000_0700, 32'h0000_0800, 2, 0, 1'b1, 0, 32'h0000_0700, 32'h0000_0800,  9,  8, 0, 1'b1};
        vecs[6] = '{32'h0000_0104, 32'h0000_020C, 2, 2, 1'b0, 0, 32'h0000_0104, 32'h0000_020C, -1, -1, 2, 1'b0};
        vecs[7] = '{32'h0000_0100, 32'h0000_0200, 3, 0, 1'b0, 0, 32'h0000_0100, 32'h0000_0200, 12,  6, 3, 1'b0};

        reset_n   = 1'b0;
        start     = 1'b0;
        src_addr  = 32'h0;
        dst_addr  = 32'h0;
        len_words = 16'h0;
        max_stall = 0;
        never     = 1'b0;
        valid_cnt = 0;
        repeat (2) @(negedge clk);
        chk("rst_busy",  {31'h0, busy},  32'h0);
        chk("rst_done",  {31'h0, done},  32'h0);
        chk("rst_error", {31'h0, error}, 32'h0);
        chk("rst_valid", {31'h0, mem_valid}, 32'h0);
        chk("rst_addr",  mem_addr,  32'h0);
        chk("rst_wdata", mem_wdata, 32'h0);
        chk("rst_wstrb", {28'h0, mem_wstrb}, 32'h0);
        reset_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 7; i++) run_job(vecs[i], i);

        // Reset while a write is outstanding: mem_valid must fall without waiting for a clock edge.
        begin
            int k;
            max_stall = 0;
            never     = 1'b0;
            @(negedge clk);
            src_addr  = 32'h0000_0A00;
            dst_addr  = 32'h0000_0B00;
            len_words = 16'd3;
            start     = 1'b1;
            @(negedge clk);
            start = 1'b0;
            k = 0;
            while (!(mem_valid && mem_wstrb == 4'hF) && k < 50) begin
                @(negedge clk);
                k++;
            end
            chk("rst_mid_reached_wr_wait", {31'h0, (mem_valid && mem_wstrb == 4'hF)}, 32'h1);
            #2;
            reset_n = 1'b0;
            #1;
            chk("rst_mid_valid_async", {31'h0, mem_valid}, 32'h0);
            chk("rst_mid_busy_async",  {31'h0, busy}, 32'h0);
            repeat (2) @(negedge clk);
            reset_n = 1'b1;
            repeat (2) @(negedge clk);
            chk("rst_mid_idle_busy",  {31'h0, busy}, 32'h0);
            chk("rst_mid_idle_valid", {31'h0, mem_valid}, 32'h0);
            chk("rst_mid_idle_done",  {31'h0, done}, 32'h0);
        end

        run_job(vecs[7], 7);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
